int_arbiter: RTL and testbench
==============================

# int_arbiter

Nested, priority-ordered interrupt arbiter that sits between the external interrupt lines and CP0 in the 5-stage MIPS core. It latches rising edges on the interrupt sources into a pending set. It selects the highest-priority pending, unmasked source that outranks everything currently in service, and requests CP0 to take it. It then tracks the in-service set until the matching `eret`. CP0 consumes `int_req`/`int_vec`, reports acceptance on `int_ack`, and reads `pending`/`in_service` as Cause.IP and the service level.

## Interface
- `NSRC`, 3: number of interrupt sources, legal 1..4; higher index = higher priority
- `VEC_BASE`, 32'h0000_0800: handler address of source 0
- `VEC_STRIDE`, 32'h0000_0080: address distance between consecutive source handlers
- `GUARD_CYC`, 2: post-acknowledge blackout cycles, legal 1..15
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `intsrc`  in  NSRC  raw interrupt lines, synchronous to `clk`
- `ie`  in  1  global interrupt enable (CP0 Status.IE)
- `im`  in  NSRC  per-source mask (Status.IM), 1 = enabled
- `int_ack`  in  1  one-cycle pulse: pipeline has taken the requested interrupt
- `eret`  in  1  one-cycle pulse: `eret` has retired
- `int_req`  out  1  interrupt request to CP0
- `int_id`  out  2  index of the requested source; valid while `int_req`=1
- `int_vec`  out  32  `VEC_BASE + int_id*VEC_STRIDE`; valid while `int_req`=1
- `pending`  out  NSRC  latched, not-yet-serviced edges (Cause.IP)
- `in_service`  out  NSRC  sources whose handlers are active

## Operation
- Edge detect: register `intsrc_q`. Set `pending[i]` when `intsrc[i] & ~intsrc_q[i]`. Levels held high do not re-trigger.
- Candidate: highest `i` with `pending[i] & im[i]` and `i` strictly greater than the highest set `in_service` bit (-1 if none). Evaluation also requires `ie`=1.
- FSM states: IDLE, REQ, GUARD.
  - IDLE: when a candidate exists, latch `int_id`/`int_vec` and go to REQ.
  - REQ: `int_req`=1. `int_id` is frozen even if a higher source arrives.
    - If `ie` drops, or `im[int_id]` drops, or `pending[int_id]` is cleared: withdraw and go to IDLE.
    - On `int_ack`: set `in_service[int_id]`, clear `pending[int_id]`, load the guard counter with `GUARD_CYC`, go to GUARD.
  - GUARD: `int_req`=0. Decrement the counter each cycle; go to IDLE when it reaches 0. This gives CP0 time to clear IE.
- `int_ack` outside REQ is ignored.
- `eret`: clear the highest set `in_service` bit. With `in_service`=0 it is a no-op.
- Simultaneous events:
  - `int_ack` and `eret` in the same cycle: `eret` clears the highest bit of the pre-ack set, then the ack bit is set.
  - New edge on source `int_id` in the same cycle as `int_ack`: `pending[int_id]` stays 1.
  - Edge and an eret-induced change in the same cycle: both take effect; the candidate is re-evaluated next cycle.
- Reset: `pending`, `in_service`, `intsrc_q`, guard counter = 0; FSM = IDLE; `int_req`=0, `int_id`=0, `int_vec`=`VEC_BASE`. Reset mid-REQ or mid-GUARD aborts without setting `in_service`.

## Timing
- All outputs are registered.
- Edge sampled at rising edge k → `pending[i]`=1 after edge k → `int_req`=1 after edge k+1. Latency is 2 cycles.
- `int_ack` sampled at edge m → `in_service` updated and `int_req`=0 after edge m. The earliest next `int_req` is after edge m+`GUARD_CYC`+1.
- `eret` sampled at edge e → `in_service` updated after edge e. A newly eligible candidate raises `int_req` after edge e+1.
- `int_req` never pulses for less than one cycle; withdrawal takes effect one cycle after the causing input.

## Configuration
- `INT_NESTING_EN` defined: the candidate must outrank the highest in-service source. Preemption is up to NSRC levels deep.
- Not defined: the candidate additionally requires `in_service`==0, so there is no nesting. Pending edges wait for `eret`. `eret` still clears the highest bit.

## Test plan
- Reset, then `ie`=1, `im`=3'b111; pulse `intsrc`=3'b100 → `pending`=3'b100 one cycle later, `int_req`=1, `int_id`=2, `int_vec`=32'h0000_0900 two cycles after the edge. After `int_ack`: `in_service`=3'b100, `pending`=0.
- While `in_service`=3'b100, pulse `intsrc`=3'b001 → `pending`=3'b001, `int_req` stays 0. Then `eret` → `in_service`=0, `int_req`=1 with `int_id`=0 after the guard and one cycle.
- `INT_NESTING_EN` defined, `in_service`=3'b001; pulse source 2 → `int_req`, `int_id`=2. Ack → `in_service`=3'b101. Two `eret`s → 3'b001 then 3'b000.
- Same stimulus without `INT_NESTING_EN` → no request until `in_service`==0.
- In REQ, drop `ie` → `int_req`=0 next cycle, `pending` unchanged. Restore `ie` → request reappears with the same `int_id`.
- Hold `intsrc[1]` high 10 cycles with a single ack → exactly one `pending` set and one request. Asserting `rst` during REQ → all outputs at reset values after the edge.

Source files
------------

// File: rtl/int_arbiter_if.sv
// Purpose : bundles the interrupt-source, CP0 handshake and status signals of int_arbiter.
// Ports   : master = CP0/pipeline side (drives sources, masks, ack, eret);
//           slave  = arbiter side (drives request, vector and status sets).
interface int_arbiter_if #(
  parameter int NSRC = 3
);
  logic [NSRC-1:0] intsrc;      // raw interrupt lines
  logic            ie;          // global interrupt enable
  logic [NSRC-1:0] im;          // per-source mask, 1 = enabled
  logic            int_ack;     // pipeline has taken the requested interrupt
  logic            eret;        // eret retired
  logic            int_req;     // interrupt request to CP0
  logic [1:0]      int_id;      // requested source index
  logic [31:0]     int_vec;     // requested handler address
  logic [NSRC-1:0] pending;     // latched, not-yet-serviced edges
  logic [NSRC-1:0] in_service;  // sources with active handlers

  modport master (
    output intsrc, ie, im, int_ack, eret,
    input  int_req, int_id, int_vec, pending, in_service
  );

  modport slave (
    input  intsrc, ie, im, int_ack, eret,
    output int_req, int_id, int_vec, pending, in_service
  );
endinterface

// File: rtl/int_arbiter.sv
// Purpose : nested priority interrupt arbiter between external lines and CP0.
// Latency : source edge -> pending after 1 cycle -> int_req after 2 cycles; all outputs registered.
// Backpr. : request held until int_ack or withdrawn (ie/im/pending drop); GUARD_CYC blackout after ack.
// Ports   : clk, rst (sync, active-high); bus = int_arbiter_if.slave.
// Config  : INT_NESTING_EN defined -> higher sources preempt active handlers;
//           undefined -> a new request is only raised while in_service is empty.
module int_arbiter #(
  parameter int          NSRC       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0080,
  parameter int          GUARD_CYC  = 2
) (
  input  logic          clk,
  input  logic          rst,
  int_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, GUARD} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] intsrc_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] isv_q, isv_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            req_q, req_d;
  logic [1:0]      id_q, id_d;
  logic [31:0]     vec_q, vec_d;

  logic            isv_any;
  logic [1:0]      isv_hi;
  logic            cand_vld;
  logic [1:0]      cand_id;
  logic [NSRC-1:0] id_mask;
  logic            ack_take;
  logic            withdraw;

  // Highest active handler level and highest eligible candidate.
  always_comb begin
    isv_any  = 1'b0;
    isv_hi   = 2'd0;
    cand_vld = 1'b0;
    cand_id  = 2'd0;
    id_mask  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (isv_q[i]) begin
        isv_any = 1'b1;
        isv_hi  = 2'(i);
      end
      id_mask[i] = (id_q == 2'(i));
    end
    for (int i = 0; i < NSRC; i++) begin
`ifdef INT_NESTING_EN
      if (pending_q[i] && bus.im[i] && (!isv_any || i > int'(isv_hi))) begin
`else
      if (pending_q[i] && bus.im[i] && !isv_any) begin
`endif
        cand_vld = 1'b1;
        cand_id  = 2'(i);
      end
    end
    cand_vld = cand_vld & bus.ie;
  end

  assign ack_take = (state_q == REQ) && bus.int_ack;
  assign withdraw = !bus.ie || !(|(bus.im & id_mask)) || !(|(pending_q & id_mask));

  // Status sets: eret drops the highest pre-ack level, then the ack sets its bit;
  // a fresh edge on the acked source keeps it pending.
  always_comb begin
    isv_d = isv_q;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.eret && isv_any && (isv_hi == 2'(i))) isv_d[i] = 1'b0;
      if (ack_take && id_mask[i])                   isv_d[i] = 1'b1;
    end
    pending_d = (pending_q & ~(ack_take ? id_mask : '0)) | (bus.intsrc & ~intsrc_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (cand_vld) begin
          id_d    = cand_id;
          vec_d   = VEC_BASE + 32'(cand_id) * VEC_STRIDE;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack wins over a coincident withdraw condition: the pipeline already took it.
        if (ack_take) begin
          cnt_d   = 4'(GUARD_CYC);
          state_d = GUARD;
        end else if (withdraw) begin
          state_d = IDLE;
        end
      end
      GUARD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      intsrc_q  <= '0;
      pending_q <= '0;
      isv_q     <= '0;
      cnt_q     <= 4'd0;
      req_q     <= 1'b0;
      id_q      <= 2'd0;
      vec_q     <= VEC_BASE;
    end else begin
      state_q   <= state_d;
      intsrc_q  <= bus.intsrc;
      pending_q <= pending_d;
      isv_q     <= isv_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
    end
  end

  assign bus.int_req    = req_q;
  assign bus.int_id     = id_q;
  assign bus.int_vec    = vec_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = isv_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Purpose : directed test of int_arbiter with a per-cycle behavioural model and literal checks.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_int_arbiter;
  localparam int          NSRC   = 3;
  localparam logic [31:0] VBASE  = 32'h0000_0800;
  localparam logic [31:0] VSTR   = 32'h0000_0080;
  localparam int          GCYC   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rises = 0;
  bit   req_prev = 1'b0;

  always #5 clk = ~clk;

  int_arbiter_if #(.NSRC(NSRC)) bus();

  int_arbiter #(
    .NSRC(NSRC), .VEC_BASE(VBASE), .VEC_STRIDE(VSTR), .GUARD_CYC(GCYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sets as bit vectors, request/guard as plain counters.
  logic [2:0] m_prev = 3'b0, m_pend = 3'b0, m_isv = 3'b0;
  bit         m_req = 1'b0;
  int         m_id = 0;
  int         m_guard = 0;
  bit         m_live = 1'b0;

  always @(posedge clk) begin : model
    logic [2:0] edges, pend_old;
    int hi, cand;
    bit ack;
    if (rst) begin
      m_prev = 3'b0; m_pend = 3'b0; m_isv = 3'b0;
      m_req = 1'b0; m_id = 0; m_guard = 0; m_live = 1'b1;
    end else begin
      edges    = bus.intsrc & ~m_prev;
      m_prev   = bus.intsrc;
      pend_old = m_pend;
      hi = -1;
      for (int i = 0; i < NSRC; i++) if (m_isv[i]) hi = i;
      cand = -1;
      for (int i = 0; i < NSRC; i++) begin
`ifdef INT_NESTING_EN
        if (m_pend[i] && bus.im[i] && i > hi) cand = i;
`else
        if (m_pend[i] && bus.im[i] && m_isv == 3'b0) cand = i;
`endif
      end
      if (!bus.ie) cand = -1;
      ack = m_req && bus.int_ack;
      if (bus.eret && hi >= 0) m_isv[hi] = 1'b0;
      if (ack) begin
        m_isv[m_id]  = 1'b1;
        m_pend[m_id] = 1'b0;
      end
      m_pend = m_pend | edges;
      if (m_req) begin
        if (ack) begin
          m_req = 1'b0;
          m_guard = GCYC;
        end else if (!bus.ie || !bus.im[m_id] || !pend_old[m_id]) begin
          m_req = 1'b0;
        end
      end else if (m_guard > 0) begin
        m_guard = m_guard - 1;
      end else if (cand >= 0) begin
        m_req = 1'b1;
        m_id  = cand;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_req", {31'b0, bus.int_req}, {31'b0, m_req});
      if (m_req) begin
        chk("m_id", {30'b0, bus.int_id}, m_id);
        chk("m_vec", bus.int_vec, VBASE + m_id * VSTR);
      end
      chk("m_pending", {29'b0, bus.pending}, {29'b0, m_pend});
      chk("m_in_service", {29'b0, bus.in_service}, {29'b0, m_isv});
    end
    if (bus.int_req && !req_prev) rises++;
    req_prev = bus.int_req;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.intsrc = '0; bus.ie = 1'b0; bus.im = '0; bus.int_ack = 1'b0; bus.eret = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("rst_req", {31'b0, bus.int_req}, 0);
    chk("rst_id", {30'b0, bus.int_id}, 0);
    chk("rst_vec", bus.int_vec, 32'h0000_0800);
    chk("rst_pend", {29'b0, bus.pending}, 0);
    chk("rst_isv", {29'b0, bus.in_service}, 0);

    // Basic request of source 2
    bus.ie = 1'b1; bus.im = 3'b111;
    bus.intsrc = 3'b100; tick(1); bus.intsrc = 3'b000;
    chk("t1_pend", {29'b0, bus.pending}, 32'b100);
    chk("t1_req0", {31'b0, bus.int_req}, 0);
    tick(1);
    chk("t1_req", {31'b0, bus.int_req}, 1);
    chk("t1_id", {30'b0, bus.int_id}, 2);
    chk("t1_vec", bus.int_vec, 32'h0000_0900);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("t1_isv", {29'b0, bus.in_service}, 32'b100);
    chk("t1_pend_clr", {29'b0, bus.pending}, 0);
    chk("t1_req_drop", {31'b0, bus.int_req}, 0);

    // Lower source waits for eret
    bus.intsrc = 3'b001; tick(1); bus.intsrc = 3'b000;
    chk("t2_pend", {29'b0, bus.pending}, 32'b001);
    tick(4);
    chk("t2_noreq", {31'b0, bus.int_req}, 0);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    chk("t2_isv", {29'b0, bus.in_service}, 0);
    chk("t2_req_lat", {31'b0, bus.int_req}, 0);
    tick(1);
    chk("t2_req", {31'b0, bus.int_req}, 1);
    chk("t2_id", {30'b0, bus.int_id}, 0);
    chk("t2_vec", bus.int_vec, 32'h0000_0800);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("t2_isv1", {29'b0, bus.in_service}, 32'b001);
    tick(3);

    // Source 2 while source 0 in service
    bus.intsrc = 3'b100; tick(1); bus.intsrc = 3'b000;
    chk("t3_pend", {29'b0, bus.pending}, 32'b100);
    tick(1);
`ifdef INT_NESTING_EN
    chk("t3_req", {31'b0, bus.int_req}, 1);
    chk("t3_id", {30'b0, bus.int_id}, 2);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("t3_isv", {29'b0, bus.in_service}, 32'b101);
    tick(3);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    chk("t3_eret1", {29'b0, bus.in_service}, 32'b001);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    chk("t3_eret2", {29'b0, bus.in_service}, 0);
`else
    chk("t3_noreq", {31'b0, bus.int_req}, 0);
    tick(3);
    chk("t3_noreq2", {31'b0, bus.int_req}, 0);
    chk("t3_pend2", {29'b0, bus.pending}, 32'b100);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    chk("t3_isv0", {29'b0, bus.in_service}, 0);
    tick(1);
    chk("t3_req", {31'b0, bus.int_req}, 1);
    chk("t3_id", {30'b0, bus.int_id}, 2);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("t3_isv", {29'b0, bus.in_service}, 32'b100);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    chk("t3_eret", {29'b0, bus.in_service}, 0);
`endif
    tick(3);

    // Withdraw on ie drop, re-raise with same id
    bus.intsrc = 3'b010; tick(1); bus.intsrc = 3'b000;
    tick(1);
    chk("t4_req", {31'b0, bus.int_req}, 1);
    chk("t4_id", {30'b0, bus.int_id}, 1);
    bus.ie = 1'b0; tick(1);
    chk("t4_wd", {31'b0, bus.int_req}, 0);
    chk("t4_pend", {29'b0, bus.pending}, 32'b010);
    bus.ie = 1'b1; tick(1);
    chk("t4_rereq", {31'b0, bus.int_req}, 1);
    chk("t4_reid", {30'b0, bus.int_id}, 1);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("t4_isv", {29'b0, bus.in_service}, 32'b010);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    tick(3);

    // Ack outside REQ is ignored
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    chk("t4b_isv", {29'b0, bus.in_service}, 0);

    // Level held high triggers once
    rises = 0;
    bus.intsrc = 3'b010; tick(2);
    chk("t5_req", {31'b0, bus.int_req}, 1);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    tick(7);
    bus.intsrc = 3'b000;
    chk("t5_pend", {29'b0, bus.pending}, 0);
    chk("t5_req0", {31'b0, bus.int_req}, 0);
    chk("t5_rises", rises, 1);
    chk("t5_isv", {29'b0, bus.in_service}, 32'b010);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    tick(3);

    // New edge on the acked source during ack keeps it pending
    bus.intsrc = 3'b001; tick(1); bus.intsrc = 3'b000;
    tick(1);
    chk("t6_req", {31'b0, bus.int_req}, 1);
    bus.intsrc = 3'b001; bus.int_ack = 1'b1; tick(1);
    bus.intsrc = 3'b000; bus.int_ack = 1'b0;
    chk("t6_pend", {29'b0, bus.pending}, 32'b001);
    chk("t6_isv", {29'b0, bus.in_service}, 32'b001);
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    chk("t6_isv0", {29'b0, bus.in_service}, 0);
    tick(2);
    chk("t6_rereq", {31'b0, bus.int_req}, 1);
    chk("t6_id", {30'b0, bus.int_id}, 0);
    bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    bus.eret = 1'b1; tick(1); bus.eret = 1'b0;
    tick(3);

    // Reset during REQ
    bus.intsrc = 3'b100; tick(1); bus.intsrc = 3'b000;
    tick(1);
    chk("t7_req", {31'b0, bus.int_req}, 1);
    rst = 1'b1; tick(1);
    chk("t7_req0", {31'b0, bus.int_req}, 0);
    chk("t7_id", {30'b0, bus.int_id}, 0);
    chk("t7_vec", bus.int_vec, 32'h0000_0800);
    chk("t7_pend", {29'b0, bus.pending}, 0);
    chk("t7_isv", {29'b0, bus.in_service}, 0);
    rst = 1'b0; tick(2);
    chk("t7_idle", {31'b0, bus.int_req}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
